imem_loader: RTL and testbench

Byte-stream program loader: the write side of the 256x8 instruction memory. It receives a length-prefixed program over a valid/ready byte interface and writes it into a writable instruction RAM port. It holds the CPU in reset until the load completes. It sits between the boot/UART byte source and the instruction memory write port, and replaces file-based preload on hardware.

---
 rtl/imem_loader_pkg.sv | 20 ++
 rtl/imem_loader_chk.sv | 34 +++
 rtl/imem_loader.sv | 140 ++++++++++++++
 tb/tb_imem_loader.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared state encoding and constants for the instruction memory loader
// No ports. Optional feature macro: IMEM_LOADER_CHECKSUM_EN (consumers only).
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN   = 3'd1,
    ST_DATA  = 3'd2,
    ST_CHK   = 3'd3,
    ST_DRAIN = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERROR = 3'd6
  } state_t;

  // A length byte of zero loads the whole memory rather than nothing.
  localparam bit LEN_ZERO_IS_FULL = 1'b1;

  localparam int CHK_W = 8;

endpackage

// File: rtl/imem_loader_chk.sv
// rtl/imem_loader_chk.sv - running modulo-256 checksum of program bytes
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   clear           zero the running sum
//   acc_en          add acc_data to the running sum this cycle
//   acc_data        byte to accumulate
//   cmp_data        received checksum byte
//   match           running sum equals cmp_data
// Used only when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader_chk
  import imem_loader_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             acc_en,
  input  logic [CHK_W-1:0] acc_data,
  input  logic [CHK_W-1:0] cmp_data,
  output logic             match
);

  logic [CHK_W-1:0] sum_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      sum_q <= '0;
    end else if (acc_en) begin
      sum_q <= sum_q + acc_data;
    end
  end

  assign match = (sum_q == cmp_data);

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - length-prefixed byte stream loader for the instruction memory write port
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               one-cycle pulse, begins a load from IDLE/DONE/ERROR
//   in_valid, in_data   byte stream from the boot source
//   in_ready            loader accepts a byte this cycle
//   mem_we/addr/wdata   instruction memory write port, one pulse per byte
//   cpu_hold            CPU held in reset except after a successful load
//   busy, done, error   load status
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN (trailing checksum byte, error state).
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int                ADDR_W    = 8,
  parameter int                DATA_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error
);

  // One extra bit so a full-memory load (2**ADDR_W bytes) is representable.
  localparam int CNT_W = ADDR_W + 1;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  remaining_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [CNT_W-1:0]  len_val;
  logic              accept;
  logic              last_byte;

  // Moore outputs decoded from the state register only.
  assign in_ready = (state_q == ST_LEN) || (state_q == ST_DATA) || (state_q == ST_CHK);
  assign busy     = in_ready || (state_q == ST_DRAIN);
  assign done     = (state_q == ST_DONE);
  assign cpu_hold = (state_q != ST_DONE);

  assign accept    = in_valid && in_ready;
  assign last_byte = (remaining_q == CNT_W'(1));

  always_comb begin
    len_val = CNT_W'(in_data);
    if (LEN_ZERO_IS_FULL && (len_val == '0)) begin
      len_val = CNT_W'(1) << ADDR_W;
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic chk_match;

  imem_loader_chk u_chk (
    .clk      (clk),
    .rst      (rst),
    .clear    (state_q == ST_LEN),
    .acc_en   ((state_q == ST_DATA) && accept),
    .acc_data (CHK_W'(in_data)),
    .cmp_data (CHK_W'(in_data)),
    .match    (chk_match)
  );

  assign error = (state_q == ST_ERROR);
`else
  assign error = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) state_d = ST_LEN;
      end
      ST_LEN: begin
        if (accept) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (accept && last_byte) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = ST_CHK;
`else
          state_d = ST_DRAIN;
`endif
        end
      end
      ST_CHK: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (accept) state_d = chk_match ? ST_DRAIN : ST_ERROR;
`else
        state_d = ST_IDLE;
`endif
      end
      // Lets the final write land before the CPU is released.
      ST_DRAIN: state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Write port is registered: a byte accepted at an edge is written one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      remaining_q <= '0;
      ptr_q       <= BASE_ADDR;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
    end else begin
      mem_we <= 1'b0;
      if ((state_q == ST_LEN) && accept) begin
        remaining_q <= len_val;
        ptr_q       <= BASE_ADDR;
      end
      if ((state_q == ST_DATA) && accept) begin
        mem_we      <= 1'b1;
        mem_addr    <= ptr_q;
        mem_wdata   <= in_data;
        ptr_q       <= ptr_q + ADDR_W'(1);
        remaining_q <= remaining_q - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - scoreboard bench driving two loaders (base 00 and base FE) with one stream
module tb_imem_loader;

  typedef struct {
    int         cyc;
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  localparam logic [7:0] BASE1 = 8'hFE;

  logic       clk = 1'b0;
  logic       rst, start, in_valid;
  logic [7:0] in_data;
  logic       in_ready0, mem_we0, cpu_hold0, busy0, done0, error0;
  logic [7:0] mem_addr0, mem_wdata0;
  logic       in_ready1, mem_we1, cpu_hold1, busy1, done1, error1;
  logic [7:0] mem_addr1, mem_wdata1;

  int  n_assert = 0;
  int  n_fail   = 0;
  int  cyc      = 0;
  wr_t q0[$];
  wr_t q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  imem_loader #(.ADDR_W(8), .DATA_W(8), .BASE_ADDR(8'h00)) dut0 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready0), .mem_we(mem_we0), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0),
    .cpu_hold(cpu_hold0), .busy(busy0), .done(done0), .error(error0)
  );

  imem_loader #(.ADDR_W(8), .DATA_W(8), .BASE_ADDR(BASE1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .cpu_hold(cpu_hold1), .busy(busy1), .done(done1), .error(error1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Write monitor: every mem_we pulse must match the oldest expected write.
  always @(negedge clk) begin
    wr_t e;
    if (mem_we0) begin
      check("wr0 pending", 32'(q0.size() != 0), 1);
      if (q0.size() != 0) begin
        e = q0.pop_front();
        check("wr0 addr", mem_addr0, e.addr);
        check("wr0 data", mem_wdata0, e.data);
        check("wr0 cycle", cyc, e.cyc);
      end
    end
    if (mem_we1) begin
      check("wr1 pending", 32'(q1.size() != 0), 1);
      if (q1.size() != 0) begin
        e = q1.pop_front();
        check("wr1 addr", mem_addr1, e.addr);
        check("wr1 data", mem_wdata1, e.data);
        check("wr1 cycle", cyc, e.cyc);
      end
    end
  end

  task automatic status(input string tag, input bit rdy, input bit hold, input bit bsy,
                        input bit dn, input bit err);
    check({tag, " in_ready0"}, in_ready0, rdy);
    check({tag, " in_ready1"}, in_ready1, rdy);
    check({tag, " cpu_hold0"}, cpu_hold0, hold);
    check({tag, " cpu_hold1"}, cpu_hold1, hold);
    check({tag, " busy0"}, busy0, bsy);
    check({tag, " done0"}, done0, dn);
    check({tag, " done1"}, done1, dn);
    check({tag, " error0"}, error0, err);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    status("start", 1, 1, 1, 0, 0);
  endtask

  // Present one byte, optionally with random stall cycles before it is taken.
  task automatic drive(input logic [7:0] b, input bit rnd, input bit is_data, input int idx);
    bit v;
    int tries = 0;
    wr_t e;
    do begin
      @(negedge clk);
      start = 1'b0;
      v = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (tries > 20) v = 1'b1;
      tries++;
      in_valid = v;
      in_data  = v ? b : 8'($urandom);
      if (v) begin
        check("ready0 on byte", in_ready0, 1);
        check("ready1 on byte", in_ready1, 1);
        if (is_data) begin
          e.cyc  = cyc + 1;
          e.data = b;
          e.addr = 8'(idx);
          q0.push_back(e);
          e.addr = BASE1 + 8'(idx);
          q1.push_back(e);
        end
      end
    end while (!v);
  endtask

  task automatic expect_done(input string tag);
    @(negedge clk);
    in_valid = 1'b0;
    status({tag, " drain"}, 0, 1, 1, 0, 0);
    @(negedge clk);
    status({tag, " done"}, 0, 0, 0, 1, 0);
    check({tag, " q0 empty"}, q0.size(), 0);
    check({tag, " q1 empty"}, q1.size(), 0);
  endtask

  task automatic run_load(input string tag, input logic [7:0] len, input logic [7:0] d[$],
                          input bit rnd);
    logic [7:0] sum = 8'h00;
    pulse_start();
    drive(len, rnd, 0, 0);
    foreach (d[i]) begin
      drive(d[i], rnd, 1, i);
      sum += d[i];
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    drive(sum, rnd, 0, 0);
`endif
    expect_done(tag);
  endtask

  initial begin
    logic [7:0] d[$];
    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (2) @(negedge clk);
    status("reset", 0, 1, 0, 0, 0);
    check("reset mem_we", mem_we0, 0);
    check("reset mem_addr", mem_addr0, 0);
    check("reset mem_wdata", mem_wdata0, 0);
    rst = 1'b0;

    d = '{8'hA1, 8'hB2, 8'hC3};
    run_load("basic", 8'd3, d, 0);

    d = '{8'h11, 8'h22, 8'h33};
    run_load("wrap", 8'd3, d, 0);

    d.delete();
    for (int i = 0; i < 256; i++) d.push_back(8'(i));
    run_load("full", 8'd0, d, 0);

    d.delete();
    for (int i = 0; i < 24; i++) d.push_back(8'($urandom));
    run_load("stall", 8'd24, d, 1);

    // Reset after two of five data bytes.
    pulse_start();
    drive(8'd5, 0, 0, 0);
    drive(8'h5A, 0, 1, 0);
    drive(8'h6B, 0, 1, 1);
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    status("midrst", 0, 1, 0, 0, 0);
    check("midrst q0 empty", q0.size(), 0);

    d = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    run_load("after rst", 8'd5, d, 0);

    // start pulsed mid-load must not restart the load.
    pulse_start();
    drive(8'd4, 0, 0, 0);
    drive(8'hC0, 0, 1, 0);
    start = 1'b1;
    drive(8'hC1, 0, 1, 1);
    drive(8'hC2, 0, 1, 2);
    drive(8'hC3, 0, 1, 3);
`ifdef IMEM_LOADER_CHECKSUM_EN
    drive(8'hC0 + 8'hC1 + 8'hC2 + 8'hC3, 0, 0, 0);
`endif
    expect_done("midstart");

`ifdef IMEM_LOADER_CHECKSUM_EN
    d = '{8'h10, 8'h20};
    run_load("chk ok", 8'd2, d, 0);

    pulse_start();
    drive(8'd2, 0, 0, 0);
    drive(8'h10, 0, 1, 0);
    drive(8'h20, 0, 1, 1);
    drive(8'h31, 0, 0, 0);
    @(negedge clk);
    in_valid = 1'b0;
    status("chk bad", 0, 1, 0, 0, 1);
    check("chk bad q0 empty", q0.size(), 0);
    pulse_start();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
`endif

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
